instruction_fetch: RTL and testbench

//  First stage of the RV32IM pipeline; producer side of the IF/ID interface consumed by decode.

---
 rtl/rv32_pipeline_pkg.sv | 36 +++
 rtl/instruction_fetch_if_id_reg.sv | 38 +++
 rtl/instruction_fetch.sv | 131 +++++++++++++
 tb/tb_instruction_fetch.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pipeline_pkg.sv
// Shared RV32 pipeline types and constants: fetch FSM states, IF/ID word, PC alignment helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rv32_pipeline_pkg;

    localparam int XLEN = 32;

    // Bytes per instruction; PC advances by this on every accepted fetch.
    localparam logic [XLEN-1:0] ILEN_BYTES = 32'd4;

    // Bubble word written into IF/ID on flush and reset: addi x0,x0,0.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // IDLE: one quiet cycle after reset.
    // REQ : request outstanding, result will be used.
    // HOLD: word parked in the skid buffer while decode is stalled.
    // DROP: request outstanding, result will be discarded (redirect arrived mid-wait).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_word_t;

    // Instruction memory is word addressed; the low two bits never reach it.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline latch: captures {instruction, pc, pc+4, valid} for decode.
// Latency: 1 cycle from word_in to outputs.
// Backpressure: stall holds contents; flush overrides stall and writes a bubble (pc fields hold).
module if_id_reg
    import rv32_pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            stall,
    input  fetch_word_t     word_in,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc4_out,
    output logic            if_valid
);

    // Flush beats stall; otherwise load unless stalled. PC fields keep their last real value on a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= NOP;
            pc_out      <= '0;
            pc4_out     <= '0;
            if_valid    <= 1'b0;
        end else if (flush) begin
            instruction <= NOP;
            if_valid    <= 1'b0;
        end else if (!stall) begin
            instruction <= word_in.instr;
            pc_out      <= word_in.pc;
            pc4_out     <= word_in.pc + ILEN_BYTES;
            if_valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// RV32 fetch stage: owns the PC, issues one word read at a time, fills the IF/ID latch.
// Latency: word enters IF/ID on the edge its imem_ready is seen; first valid 2 cycles after reset release.
// Backpressure: stall parks an arriving word in a 1-entry skid and drops imem_req; redirect flushes and refetches.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = rv32_pipeline_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out,
    output logic        if_valid
);

    import rv32_pipeline_pkg::*;

    fetch_state_t    state;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pending_pc;

    // Skid contents are meaningful exactly while state is HOLD, so no separate valid bit.
    fetch_word_t     skid;

    logic [XLEN-1:0] target;
    logic            fire;
    logic            have_word;
    logic            id_flush;
    fetch_word_t     id_word;

    assign target    = word_align(redirect_pc);
    assign fire      = (state == REQ) && imem_ready;
    assign have_word = fire || (state == HOLD);

    // A redirect always squashes IF/ID; an unstalled cycle with nothing to deliver inserts a bubble.
    assign id_flush  = redirect || (!stall && !have_word);
    assign id_word   = (state == HOLD) ? skid : {imem_rdata, pc_reg};

    // The address is the PC itself; it only moves once the outstanding request has completed.
    assign imem_addr = pc_reg;

    // Fetch FSM: PC, request strobe, skid buffer and pending redirect target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc_reg     <= RESET_PC;
            pending_pc <= RESET_PC;
            skid       <= '0;
            imem_req   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                    if (redirect) begin
                        pc_reg <= target;
                    end
                end

                REQ: begin
                    if (imem_ready) begin
                        if (redirect) begin
                            // Returned word belongs to the wrong path; refetch at target next cycle.
                            pc_reg <= target;
                        end else if (!stall) begin
                            pc_reg <= pc_reg + ILEN_BYTES;
                        end else begin
                            // Decode is frozen: park the word and stop requesting until it drains.
                            skid     <= '{instr: imem_rdata, pc: pc_reg};
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end
                    end else if (redirect) begin
                        // Request already on the bus: keep address stable, remember where to go.
                        pending_pc <= target;
                        state      <= DROP;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        pc_reg   <= target;
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end else if (!stall) begin
                        pc_reg   <= pc_reg + ILEN_BYTES;
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end

                DROP: begin
                    if (imem_ready) begin
                        // Discard the stale word; a redirect arriving now is the newest target.
                        pc_reg <= redirect ? target : pending_pc;
                        state  <= REQ;
                    end else if (redirect) begin
                        pending_pc <= target;
                    end
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP (NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .reset       (reset),
        .flush       (id_flush),
        .stall       (stall),
        .word_in     (id_word),
        .instruction (instruction),
        .pc_out      (pc_out),
        .pc4_out     (pc4_out),
        .if_valid    (if_valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed stimulus, reference model of fetch behaviour, per-cycle compare.
// Latency: not applicable.
// Backpressure: memory latency set per phase through ready_delay.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] pc4_out;
    logic        if_valid;

    int ready_delay = 0;
    int wait_cnt = 0;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .instruction (instruction),
        .pc_out      (pc_out),
        .pc4_out     (pc4_out),
        .if_valid    (if_valid)
    );

    // Memory contents: each word is its own address xor a marker, so misdirected fetches show up.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0003;
    endfunction

    assign imem_rdata = instr_of(imem_addr);
    assign imem_ready = imem_req && (wait_cnt >= ready_delay);

    // Count cycles the current request has been waiting.
    always @(posedge clk) wait_cnt <= (imem_req && !imem_ready) ? wait_cnt + 1 : 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Abstract view: after the first cycle a request is always outstanding unless a
    // word is parked; a redirect during a wait marks the current request as dropped.
    bit          m_started, m_skid_full, m_dropping;
    logic [31:0] m_pc, m_target, m_skid_instr, m_skid_pc;
    logic [31:0] m_instr, m_pcout, m_pc4;
    bit          m_valid;
    int          m_wait;

    task automatic model_reset();
        m_started = 0; m_skid_full = 0; m_dropping = 0;
        m_pc = 32'h0; m_target = 32'h0; m_skid_instr = 32'h0; m_skid_pc = 32'h0;
        m_instr = NOP; m_pcout = 32'h0; m_pc4 = 32'h0; m_valid = 0; m_wait = 0;
    endtask

    task automatic bubble();
        m_instr = NOP;
        m_valid = 0;
    endtask

    task automatic deliver(input logic [31:0] ins, input logic [31:0] pc);
        m_instr = ins; m_pcout = pc; m_pc4 = pc + 32'd4; m_valid = 1;
    endtask

    task automatic model_step();
        bit req, got;
        logic [31:0] tgt;
        req = m_started && !m_skid_full;
        got = req && (m_wait >= ready_delay);
        tgt = redirect_pc & 32'hFFFF_FFFC;
        m_wait = (req && !got) ? m_wait + 1 : 0;
        if (!m_started) begin
            m_started = 1;
            if (redirect) m_pc = tgt;
            if (redirect || !stall) bubble();
        end else if (m_skid_full) begin
            if (redirect) begin
                m_skid_full = 0; m_pc = tgt; bubble();
            end else if (!stall) begin
                m_skid_full = 0; deliver(m_skid_instr, m_skid_pc); m_pc = m_pc + 32'd4;
            end
        end else if (redirect) begin
            if (got) begin m_pc = tgt; m_dropping = 0; end
            else begin m_dropping = 1; m_target = tgt; end
            bubble();
        end else if (got && m_dropping) begin
            m_pc = m_target; m_dropping = 0;
            if (!stall) bubble();
        end else if (got && stall) begin
            m_skid_full = 1; m_skid_instr = instr_of(m_pc); m_skid_pc = m_pc;
        end else if (got) begin
            deliver(instr_of(m_pc), m_pc); m_pc = m_pc + 32'd4;
        end else if (!stall) begin
            bubble();
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("req", {31'b0, imem_req}, {31'b0, (m_started && !m_skid_full)});
            if (m_started && !m_skid_full) check("addr", imem_addr, m_pc);
            check("instr", instruction, m_instr);
            check("pc_out", pc_out, m_pcout);
            check("pc4_out", pc4_out, m_pc4);
            check("valid", {31'b0, if_valid}, {31'b0, m_valid});
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        #1 reset = 1'b0;
        repeat (3) nxt();
        check("lit_rst_valid", {31'b0, if_valid}, 32'd0);
        check("lit_rst_instr", instruction, 32'h0000_0013);
        check("lit_rst_req", {31'b0, imem_req}, 32'd0);
        check("lit_rst_pc", pc_out, 32'h0);
        reset = 1'b1;

        // Sequential fetch with single-cycle memory.
        nxt();
        check("lit_t1_req", {31'b0, imem_req}, 32'd1);
        check("lit_t1_addr0", imem_addr, 32'h0);
        check("lit_t1_novalid", {31'b0, if_valid}, 32'd0);
        nxt();
        check("lit_t1_v0", {31'b0, if_valid}, 32'd1);
        check("lit_t1_pc0", pc_out, 32'h0);
        check("lit_t1_i0", instruction, 32'hDEAD_0003);
        check("lit_t1_pc4", pc4_out, 32'h4);
        nxt();
        check("lit_t1_pc1", pc_out, 32'h4);
        check("lit_t1_i1", instruction, 32'hDEAD_0007);
        nxt();
        check("lit_t1_pc2", pc_out, 32'h8);
        check("lit_t1_i2", instruction, 32'hDEAD_000B);
        check("lit_t1_pc4_2", pc4_out, 32'hC);

        // Stall for three cycles while the word at 0xC returns.
        stall = 1'b1;
        nxt();
        check("lit_t2_req_low", {31'b0, imem_req}, 32'd0);
        check("lit_t2_frozen", pc_out, 32'h8);
        nxt();
        nxt();
        check("lit_t2_frozen3", pc_out, 32'h8);
        stall = 1'b0;
        nxt();
        check("lit_t2_skid_pc", pc_out, 32'hC);
        check("lit_t2_skid_i", instruction, 32'hDEAD_000F);
        check("lit_t2_next_addr", imem_addr, 32'h10);
        nxt();
        check("lit_t2_nodup", pc_out, 32'h10);

        // Redirect with ready in the same cycle; low address bits dropped.
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        nxt();
        redirect = 1'b0;
        check("lit_t3_bubble", {31'b0, if_valid}, 32'd0);
        check("lit_t3_nop", instruction, 32'h0000_0013);
        check("lit_t3_pchold", pc_out, 32'h10);
        check("lit_t3_addr", imem_addr, 32'h100);
        nxt();
        check("lit_t3_target", pc_out, 32'h100);
        check("lit_t3_ti", instruction, 32'hDEAD_0103);

        // Redirect during a 3-cycle memory wait.
        ready_delay = 3; redirect = 1'b1; redirect_pc = 32'h200;
        nxt();
        redirect = 1'b0;
        check("lit_t4_addr_a", imem_addr, 32'h104);
        nxt();
        check("lit_t4_addr_b", imem_addr, 32'h104);
        nxt();
        check("lit_t4_addr_c", imem_addr, 32'h104);
        check("lit_t4_req", {31'b0, imem_req}, 32'd1);
        nxt();
        check("lit_t4_target", imem_addr, 32'h200);
        check("lit_t4_dropped", {31'b0, if_valid}, 32'd0);
        ready_delay = 0;
        nxt();
        check("lit_t4_pc", pc_out, 32'h200);
        check("lit_t4_i", instruction, 32'hDEAD_0203);

        // Redirect and stall together while a word is parked.
        stall = 1'b1;
        nxt();
        check("lit_t5_hold", {31'b0, imem_req}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h300;
        nxt();
        redirect = 1'b0; stall = 1'b0;
        check("lit_t5_bubble", {31'b0, if_valid}, 32'd0);
        check("lit_t5_pchold", pc_out, 32'h200);
        check("lit_t5_addr", imem_addr, 32'h300);
        nxt();
        check("lit_t5_pc", pc_out, 32'h300);
        check("lit_t5_i", instruction, 32'hDEAD_0303);

        // PC wraparound at the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        nxt();
        redirect = 1'b0;
        check("lit_t6_addr", imem_addr, 32'hFFFF_FFFC);
        nxt();
        check("lit_t6_pc", pc_out, 32'hFFFF_FFFC);
        check("lit_t6_pc4", pc4_out, 32'h0);
        check("lit_t6_i", instruction, 32'h2152_FFFF);
        check("lit_t6_wrap", imem_addr, 32'h0);
        nxt();
        check("lit_t6_pcw", pc_out, 32'h0);

        // Asynchronous reset in the middle of a memory wait.
        ready_delay = 5;
        nxt();
        nxt();
        check("lit_t6_waiting", {31'b0, imem_req}, 32'd1);
        check("lit_t6_waddr", imem_addr, 32'h4);
        #2 reset = 1'b0;
        #1;
        check("lit_ar_req", {31'b0, imem_req}, 32'd0);
        check("lit_ar_valid", {31'b0, if_valid}, 32'd0);
        check("lit_ar_instr", instruction, 32'h0000_0013);
        check("lit_ar_pc", pc_out, 32'h0);
        check("lit_ar_pc4", pc4_out, 32'h0);
        ready_delay = 0;
        nxt();
        reset = 1'b1;
        nxt();
        check("lit_ar_addr", imem_addr, 32'h0);
        nxt();
        check("lit_ar_first", {31'b0, if_valid}, 32'd1);
        check("lit_ar_firstpc", pc_out, 32'h0);
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
